// File: rtl/prng_stream_ctrl_pkg.sv
// Shared types for the PRNG stream controller: counter type, block width and FSM states.
package TYPES;

  localparam int unsigned PRNG_BLK_W = 256;
  localparam int unsigned CR_CNT_W   = 16;

  typedef logic [CR_CNT_W-1:0] cr_cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } ctrl_state_e;

endpackage

// File: rtl/prng_stream_ctrl_if.sv
// Show-ahead output stream of 256-bit PRNG blocks (valid/ready, pop when both high).
interface prng_stream_ctrl_if;
  import TYPES::*;

  logic [PRNG_BLK_W-1:0] rd_data;
  logic                  rd_vld;
  logic                  rd_rdy;

  modport master (output rd_data, output rd_vld, input rd_rdy);
  modport slave  (input rd_data, input rd_vld, output rd_rdy);

endinterface

// File: rtl/prng_out_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; a pop frees room for a same-cycle push.
module prng_out_fifo
  import TYPES::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned Aw = $clog2(Depth),
  localparam int unsigned Cw = Aw + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [PRNG_BLK_W-1:0] push_data,
  input  logic                  pop,
  output logic [PRNG_BLK_W-1:0] head,
  output logic                  vld,
  output logic                  full,
  output logic [Cw-1:0]         count
);

  logic [PRNG_BLK_W-1:0] mem [Depth];
  logic [Aw-1:0]         wr_ptr_q, rd_ptr_q;
  logic [Cw-1:0]         count_q;
  logic                  do_push, do_pop;

  assign vld     = (count_q != '0);
  assign full    = (count_q == Cw'(Depth));
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_pop  = pop && vld;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + Aw'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + Aw'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + Cw'(1);
        2'b01:   count_q <= count_q - Cw'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/prng_stream_ctrl.sv
// Issues counter/prefix requests to a PRNG under FIFO credit control and buffers its output blocks.
module prng_stream_ctrl
  import TYPES::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  start,
  input  cr_cnt_t               start_cnt,
  input  cr_cnt_t               num_blk,
  input  logic [6:0]            prefix_in,
  output logic                  busy,
  output logic                  done,
  output cr_cnt_t               prng_cnt,
  output logic [6:0]            prng_prefix,
  output logic                  prng_drdy,
  input  logic [PRNG_BLK_W-1:0] prng_dout,
  input  logic                  prng_dvld,
  prng_stream_ctrl_if.master    rd,
  output logic                  ovf_err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] DepthVal = (CntW + 1)'(FIFO_DEPTH);

  ctrl_state_e     state_q;
  cr_cnt_t         remaining_q;
  logic [CntW-1:0] reserved_q, reserved_d;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   credit_sum;
  logic            fifo_full, pop_now, ovf_set, fifo_push;
  logic            issue_go, ret_ok;

  assign busy       = (state_q != StIdle);
  assign pop_now    = rd.rd_vld && rd.rd_rdy;
  assign ovf_set    = prng_dvld && fifo_full && !pop_now;
  assign fifo_push  = prng_dvld && !ovf_set;
  assign credit_sum = {1'b0, reserved_q} + {1'b0, fifo_count};
  // Credit is reserved on the decision edge so back-to-back issues never oversubscribe the FIFO.
  assign issue_go   = (state_q == StIssue) && (remaining_q != '0) && (credit_sum < DepthVal);
  assign ret_ok     = prng_dvld && (reserved_q != '0);

  always_comb begin
    reserved_d = reserved_q;
    if (issue_go && !ret_ok) begin
      reserved_d = reserved_q + CntW'(1);
    end else if (!issue_go && ret_ok) begin
      reserved_d = reserved_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      reserved_q  <= '0;
      prng_cnt    <= '0;
      prng_prefix <= '0;
      prng_drdy   <= 1'b0;
      done        <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      done       <= 1'b0;
      prng_drdy  <= issue_go;
      reserved_q <= reserved_d;
      if (prng_drdy) begin
        prng_cnt <= prng_cnt + cr_cnt_t'(1);
      end
      if (ovf_set) begin
        ovf_err <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_blk != '0) begin
              prng_cnt    <= start_cnt;
              prng_prefix <= prefix_in;
              remaining_q <= num_blk;
              state_q     <= StIssue;
            end else begin
              done <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (issue_go) begin
            remaining_q <= remaining_q - cr_cnt_t'(1);
            if (remaining_q == cr_cnt_t'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (reserved_q == '0) begin
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  prng_out_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RSTn),
    .push     (fifo_push),
    .push_data(prng_dout),
    .pop      (rd.rd_rdy),
    .head     (rd.rd_data),
    .vld      (rd.rd_vld),
    .full     (fifo_full),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_prng_stream_ctrl.sv
// Bench for prng_stream_ctrl: fixed-latency PRNG model, table-driven jobs plus stall/reset/overflow cases.
module tb_prng_stream_ctrl;
  import TYPES::*;

  localparam int unsigned Depth = 8;
  localparam int Lat = 20;

  logic                  CLK = 1'b0;
  logic                  RSTn = 1'b0;
  logic                  start;
  cr_cnt_t               start_cnt, num_blk, prng_cnt;
  logic [6:0]            prefix_in, prng_prefix;
  logic                  busy, done, prng_drdy, prng_dvld, ovf_err;
  logic [PRNG_BLK_W-1:0] prng_dout;

  prng_stream_ctrl_if rd_if ();

  prng_stream_ctrl #(.FIFO_DEPTH(Depth)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .start      (start),
    .start_cnt  (start_cnt),
    .num_blk    (num_blk),
    .prefix_in  (prefix_in),
    .busy       (busy),
    .done       (done),
    .prng_cnt   (prng_cnt),
    .prng_prefix(prng_prefix),
    .prng_drdy  (prng_drdy),
    .prng_dout  (prng_dout),
    .prng_dvld  (prng_dvld),
    .rd         (rd_if),
    .ovf_err    (ovf_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [PRNG_BLK_W-1:0] blk_of(cr_cnt_t c, logic [6:0] p);
    return {{15{c}}, c ^ {p, 9'h1a5}};
  endfunction

  // PRNG model: drdy at cycle k returns dvld at cycle k+Lat.
  logic                  pipe_v [Lat];
  logic [PRNG_BLK_W-1:0] pipe_d [Lat];
  logic                  force_v = 1'b0;
  logic [PRNG_BLK_W-1:0] force_d = '0;

  always @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < Lat; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= prng_drdy;
      pipe_d[0] <= blk_of(prng_cnt, prng_prefix);
      for (int i = 1; i < Lat; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign prng_dvld = pipe_v[Lat-1] | force_v;
  assign prng_dout = force_v ? force_d : pipe_d[Lat-1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  cr_cnt_t               iss_cnt [$];
  logic [6:0]            iss_pfx [$];
  logic [PRNG_BLK_W-1:0] beats [$];
  int n_done = 0, done_cyc = -1, last_dvld_cyc = -1, start_cyc = 0;
  logic busy_seen = 1'b0;

  always @(negedge CLK) begin
    if (RSTn) begin
      if (prng_drdy) begin
        iss_cnt.push_back(prng_cnt);
        iss_pfx.push_back(prng_prefix);
      end
      if (rd_if.rd_vld && rd_if.rd_rdy) beats.push_back(rd_if.rd_data);
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (prng_dvld) last_dvld_cyc = cyc;
      if (busy) busy_seen = 1'b1;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check(string name, logic [PRNG_BLK_W-1:0] act, logic [PRNG_BLK_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(cr_cnt_t sc, cr_cnt_t nb, logic [6:0] p);
    iss_cnt.delete();
    iss_pfx.delete();
    beats.delete();
    n_done = 0;
    done_cyc = -1;
    busy_seen = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1;
    start_cnt = sc;
    num_blk = nb;
    prefix_in = p;
    start_cyc = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge CLK);
      k++;
    end
    check("done_within_budget", PRNG_BLK_W'(n_done != 0), PRNG_BLK_W'(1));
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic verify(cr_cnt_t sc, int n, logic [6:0] p, cr_cnt_t first, cr_cnt_t last);
    check("issue_count", PRNG_BLK_W'(iss_cnt.size()), PRNG_BLK_W'(n));
    if (iss_cnt.size() > 0) begin
      check("first_cnt", PRNG_BLK_W'(iss_cnt[0]), PRNG_BLK_W'(first));
      check("last_cnt", PRNG_BLK_W'(iss_cnt[$]), PRNG_BLK_W'(last));
    end
    for (int i = 0; i < iss_pfx.size(); i++) begin
      check("prefix", PRNG_BLK_W'(iss_pfx[i]), PRNG_BLK_W'(p));
    end
    check("beat_count", PRNG_BLK_W'(beats.size()), PRNG_BLK_W'(n));
    for (int i = 0; i < beats.size() && i < n; i++) begin
      check("beat_data", beats[i], blk_of(sc + cr_cnt_t'(i), p));
    end
    check("done_pulses", PRNG_BLK_W'(n_done), PRNG_BLK_W'(1));
    check("done_after_dvld", PRNG_BLK_W'(done_cyc > last_dvld_cyc), PRNG_BLK_W'(1));
    check("ovf_clear", PRNG_BLK_W'(ovf_err), PRNG_BLK_W'(0));
    check("busy_idle", PRNG_BLK_W'(busy), PRNG_BLK_W'(0));
  endtask

  typedef struct {
    cr_cnt_t    scnt;
    cr_cnt_t    nblk;
    logic [6:0] pfx;
    cr_cnt_t    exp_first;
    cr_cnt_t    exp_last;
    int         exp_n;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{16'h0010, 16'd3,  7'h2A, 16'h0010, 16'h0012, 3};
    vecs[1] = '{16'hFFFF, 16'd2,  7'h11, 16'hFFFF, 16'h0000, 2};
    vecs[2] = '{16'h0100, 16'd1,  7'h7F, 16'h0100, 16'h0100, 1};
    vecs[3] = '{16'h00F8, 16'd10, 7'h05, 16'h00F8, 16'h0101, 10};

    start = 1'b0;
    start_cnt = '0;
    num_blk = '0;
    prefix_in = '0;
    rd_if.rd_rdy = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", PRNG_BLK_W'(busy), '0);
    check("rst_done", PRNG_BLK_W'(done), '0);
    check("rst_drdy", PRNG_BLK_W'(prng_drdy), '0);
    check("rst_rd_vld", PRNG_BLK_W'(rd_if.rd_vld), '0);
    check("rst_ovf", PRNG_BLK_W'(ovf_err), '0);
    check("rst_cnt", PRNG_BLK_W'(prng_cnt), '0);
    check("rst_prefix", PRNG_BLK_W'(prng_prefix), '0);
    RSTn = 1'b1;

    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].scnt, vecs[v].nblk, vecs[v].pfx);
      wait_done(600);
      verify(vecs[v].scnt, vecs[v].exp_n, vecs[v].pfx, vecs[v].exp_first, vecs[v].exp_last);
    end

    // Zero-length job: immediate done, never busy.
    launch(16'h0055, 16'd0, 7'h33);
    repeat (4) @(posedge CLK);
    #1;
    check("zero_done_cycle", PRNG_BLK_W'(done_cyc), PRNG_BLK_W'(start_cyc + 1));
    check("zero_done_pulses", PRNG_BLK_W'(n_done), PRNG_BLK_W'(1));
    check("zero_no_issue", PRNG_BLK_W'(iss_cnt.size()), '0);
    check("zero_busy_seen", PRNG_BLK_W'(busy_seen), '0);

    // Consumer stalled: credit caps outstanding+buffered at Depth.
    rd_if.rd_rdy = 1'b0;
    launch(16'h0200, 16'd12, 7'h44);
    repeat (60) @(posedge CLK);
    #1;
    check("stall_issues", PRNG_BLK_W'(iss_cnt.size()), PRNG_BLK_W'(8));
    check("stall_busy", PRNG_BLK_W'(busy), PRNG_BLK_W'(1));
    check("stall_rd_vld", PRNG_BLK_W'(rd_if.rd_vld), PRNG_BLK_W'(1));
    check("stall_no_done", PRNG_BLK_W'(n_done), '0);
    rd_if.rd_rdy = 1'b1;
    wait_done(600);
    verify(16'h0200, 12, 7'h44, 16'h0200, 16'h020B);

    // start while a job runs is ignored.
    launch(16'h0300, 16'd5, 7'h22);
    repeat (2) @(posedge CLK);
    #1;
    start = 1'b1;
    start_cnt = 16'h0999;
    num_blk = 16'd0;
    prefix_in = 7'h01;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(600);
    verify(16'h0300, 5, 7'h22, 16'h0300, 16'h0304);

    // One-cycle reset mid-job abandons it silently.
    launch(16'h0500, 16'd6, 7'h0C);
    repeat (5) @(posedge CLK);
    #1;
    RSTn = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    check("midrst_busy", PRNG_BLK_W'(busy), '0);
    check("midrst_rd_vld", PRNG_BLK_W'(rd_if.rd_vld), '0);
    check("midrst_drdy", PRNG_BLK_W'(prng_drdy), '0);
    iss_cnt.delete();
    beats.delete();
    repeat (40) @(posedge CLK);
    #1;
    check("midrst_no_done", PRNG_BLK_W'(n_done), '0);
    check("midrst_no_beats", PRNG_BLK_W'(beats.size()), '0);
    check("midrst_no_issue", PRNG_BLK_W'(iss_cnt.size()), '0);

    // Fill the FIFO, then force a return with no room.
    rd_if.rd_rdy = 1'b0;
    launch(16'h0400, 16'd8, 7'h3C);
    wait_done(600);
    check("full_rd_vld", PRNG_BLK_W'(rd_if.rd_vld), PRNG_BLK_W'(1));
    check("full_ovf_before", PRNG_BLK_W'(ovf_err), '0);
    check("full_head_before", rd_if.rd_data, blk_of(16'h0400, 7'h3C));
    @(posedge CLK); #1;
    force_v = 1'b1;
    force_d = '1;
    @(posedge CLK); #1;
    force_v = 1'b0;
    check("ovf_set", PRNG_BLK_W'(ovf_err), PRNG_BLK_W'(1));
    check("ovf_head_kept", rd_if.rd_data, blk_of(16'h0400, 7'h3C));
    repeat (10) @(posedge CLK);
    #1;
    check("ovf_sticky", PRNG_BLK_W'(ovf_err), PRNG_BLK_W'(1));
    beats.delete();
    rd_if.rd_rdy = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    check("ovf_beat_count", PRNG_BLK_W'(beats.size()), PRNG_BLK_W'(8));
    for (int i = 0; i < beats.size() && i < 8; i++) begin
      check("ovf_beat_data", beats[i], blk_of(16'h0400 + cr_cnt_t'(i), 7'h3C));
    end
    check("ovf_drained", PRNG_BLK_W'(rd_if.rd_vld), '0);
    check("ovf_still_set", PRNG_BLK_W'(ovf_err), PRNG_BLK_W'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prng_stream_ctrl.md
PRNG_STREAM_CTRL -- requirements
Module: prng_stream_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of 256-bit output buffer entries (power of two, >=2).
REQ-002 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have port RSTn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  in  1  job request, sampled only in IDLE.
REQ-005 SHALL have port start_cnt  in  cr_cnt_t  first counter value of the job.
REQ-006 SHALL have port num_blk  in  cr_cnt_t  number of 256-bit blocks to generate.
REQ-007 SHALL have port prefix_in  in  7  job prefix.
REQ-008 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-009 SHALL have port done  out  1  one-cycle pulse at job completion.
REQ-010 SHALL have port prng_cnt  out  cr_cnt_t  counter presented to the PRNG.
REQ-011 SHALL have port prng_prefix  out  7  prefix presented to the PRNG.
REQ-012 SHALL have port prng_drdy  out  1  PRNG input strobe.
REQ-013 SHALL have port prng_dout  in  256  PRNG output block.
REQ-014 SHALL have port prng_dvld  in  1  PRNG output strobe; no backpressure is possible on it.
REQ-015 SHALL have port rd_data  out  256  FIFO head (show-ahead).
REQ-016 SHALL have port rd_vld  out  1  FIFO not empty.
REQ-017 SHALL have port rd_rdy  in  1  consumer accept; a pop occurs when rd_vld and rd_rdy are both high.
REQ-018 SHALL have port ovf_err  out  1  sticky overflow flag.

Function
REQ-019 SHALL implement states IDLE, ISSUE and DRAIN.
REQ-020 IDLE behaviour on start:
  - start=1 and num_blk>0: latch start_cnt into prng_cnt, prefix_in into prng_prefix, num_blk into remaining; go to ISSUE.
  - start=1 and num_blk=0: pulse done in the next cycle; stay in IDLE.
REQ-021 SHALL ignore start while in ISSUE or DRAIN.
REQ-022 ISSUE SHALL assert the registered prng_drdy for one cycle per block, only when remaining>0 and reserved+fifo_count<FIFO_DEPTH, evaluated on current registered values; a pop in the same cycle does not add credit.
  - reserved counts blocks issued but not yet returned.
REQ-023 Each issued cycle SHALL do the following:
  - prng_cnt is the value for that block;
  - on the following edge prng_cnt increments modulo 2^$bits(cr_cnt_t) (wrap-around, no flag);
  - remaining decrements;
  - reserved increments.
REQ-024 When the last block has been issued, the state SHALL move to DRAIN; prng_prefix SHALL stay constant for the whole job.
REQ-025 prng_dvld SHALL push prng_dout into the FIFO and decrement reserved; a simultaneous issue and return SHALL leave reserved unchanged.
REQ-026 DRAIN SHALL wait until reserved=0, then pulse done for one cycle and return to IDLE; data still queued in the FIFO does not delay done.
REQ-027 The FIFO SHALL be first-in first-out with push/pop in the same cycle allowed at any fill level except a push when full.
REQ-028 prng_dvld while the FIFO is full and not popping SHALL drop the data, set ovf_err (sticky until reset), and leave FIFO contents unchanged.
REQ-029 Output order on rd_data SHALL equal issue order.

Reset
REQ-030 With RSTn low at a rising edge, all of the following SHALL hold the next cycle:
  - state IDLE;
  - busy, done, prng_drdy, rd_vld and ovf_err are 0;
  - prng_cnt, prng_prefix, remaining and reserved are 0;
  - FIFO is empty.
REQ-031 Reset mid-job SHALL abandon the job without a done pulse; the PRNG pipeline shares RSTn, so no stale prng_dvld is expected afterwards.

Structure
REQ-032 cr_cnt_t and constant PRNG_BLK_W=256 SHALL reside in package TYPES; FIFO_DEPTH remains a module parameter.
REQ-033 The FIFO SHALL be the sub-module prng_out_fifo (synchronous, show-ahead, with count output); the FSM and credit logic remain in prng_stream_ctrl.

Verification (bench models the PRNG as a fixed-latency pipeline, latency 20, Dout = f(cnt,prefix))
REQ-034 start_cnt=0x10, num_blk=3, prefix_in=0x2A, rd_rdy=1 -> prng_drdy with prng_cnt 0x10, 0x11, 0x12 and prng_prefix 0x2A; three rd beats in that order; one done pulse after the third prng_dvld.
REQ-035 num_blk=0 -> done high exactly one cycle after start; prng_drdy never asserted; busy stays 0.
REQ-036 rd_rdy=0, num_blk=12 -> exactly 8 prng_drdy pulses, then stall; after rd_rdy=1 the remaining 4 issue; 12 beats out; ovf_err=0.
REQ-037 start_cnt=all-ones, num_blk=2 -> prng_cnt all-ones then 0.
REQ-038 start pulsed mid-job -> ignored; RSTn low for 1 cycle mid-job -> next cycle busy=0, rd_vld=0, prng_drdy=0, no done.
REQ-039 Forced prng_dvld with FIFO full and rd_rdy=0 -> ovf_err=1 and stays 1; FIFO head and count unchanged.
